// File: rtl/garbage_inserter.sv
// rtl/garbage_inserter.sv - pushes pending garbage rows up from the bottom of a board
// One row per cycle after a piece lock; each row is solid except one LFSR-picked hole.
module garbage_inserter #(
    parameter int          BOARD_H       = 20,
    parameter int          ROW_W         = 12,
    parameter int          MAX_PENDING   = 20,
    parameter int          MAX_PER_APPLY = 4,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       add_valid,
    input  logic [4:0]                 add_lines,
    input  logic                       apply_req,
    input  logic [BOARD_H*ROW_W-1:0]   board_in,
    output logic [BOARD_H*ROW_W-1:0]   board_out,
    output logic                       busy,
    output logic                       done,
    output logic                       topout,
    output logic [2:0]                 inserted,
    output logic [4:0]                 pending
);
    localparam int          BW   = BOARD_H * ROW_W;
    localparam int          HW   = $clog2(ROW_W);
    localparam logic [5:0]  MAXP = 6'(MAX_PENDING);
    localparam logic [4:0]  MAXA = 5'(MAX_PER_APPLY);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state, state_next;
    logic [7:0]      lfsr;
    logic [HW-1:0]   hole_now, hole_q;
    logic [BW-1:0]   work, board_q;
    logic [2:0]      cnt, n_q, n_apply, inserted_q;
    logic            topacc, topout_q;
    logic [5:0]      pend_sum;
    logic [4:0]      pending_next;
    logic [ROW_W-1:0] garbage_row;

    assign hole_now    = HW'(lfsr % 8'(ROW_W));
    assign garbage_row = ~({{(ROW_W-1){1'b0}}, 1'b1} << hole_q);
    assign n_apply     = 3'((pending > MAXA) ? MAXA : pending);

    // DONE-cycle decrement and a same-cycle add are folded into one 6-bit sum
    always_comb begin
        pend_sum = {1'b0, pending};
        if (state == DONE)
            pend_sum = pend_sum - {3'b000, n_q};
        if (add_valid)
            pend_sum = pend_sum + {1'b0, add_lines};
        pending_next = (pend_sum > MAXP) ? MAXP[4:0] : pend_sum[4:0];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (apply_req) state_next = (n_apply != 3'd0) ? SHIFT : DONE;
            SHIFT:   if (cnt == 3'd1) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            pending    <= 5'd0;
            work       <= '0;
            board_q    <= '0;
            hole_q     <= '0;
            cnt        <= 3'd0;
            n_q        <= 3'd0;
            inserted_q <= 3'd0;
            topacc     <= 1'b0;
            topout_q   <= 1'b0;
        end else begin
            state   <= state_next;
            lfsr    <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            pending <= pending_next;
            case (state)
                IDLE: if (apply_req) begin
                    work   <= board_in;
                    hole_q <= hole_now;
                    n_q    <= n_apply;
                    cnt    <= n_apply;
                    topacc <= 1'b0;
                end
                SHIFT: begin
                    topacc <= topacc | (|work[BW-1 -: ROW_W]);
                    work   <= {work[BW-ROW_W-1:0], garbage_row};
                    cnt    <= cnt - 3'd1;
                end
                DONE: begin
                    board_q    <= work;
                    topout_q   <= topacc;
                    inserted_q <= n_q;
                end
                default: ;
            endcase
        end
    end

    // Results show live during DONE, then hold from the shadow registers
    assign done      = (state == DONE);
    assign busy      = (state != IDLE);
    assign board_out = done ? work   : board_q;
    assign topout    = done ? topacc : topout_q;
    assign inserted  = done ? n_q    : inserted_q;
endmodule

// File: tb/tb_garbage_inserter.sv
// tb/tb_garbage_inserter.sv - directed self-checking bench for garbage_inserter
module tb_garbage_inserter;
    localparam int BW = 240;

    logic          clk = 1'b0;
    logic          rst, add_valid, apply_req;
    logic [4:0]    add_lines;
    logic [BW-1:0] board_in, board_out;
    logic          busy, done, topout;
    logic [2:0]    inserted;
    logic [4:0]    pending;
    logic [7:0]    lfsr_m;
    int            checks = 0;
    int            failures = 0;

    garbage_inserter dut (
        .clk(clk), .rst(rst), .add_valid(add_valid), .add_lines(add_lines),
        .apply_req(apply_req), .board_in(board_in), .board_out(board_out),
        .busy(busy), .done(done), .topout(topout), .inserted(inserted),
        .pending(pending)
    );

    always #5 clk = ~clk;

    // Reference hole generator: 8-bit Fibonacci, taps 8,6,5,4
    always @(posedge clk)
        lfsr_m <= rst ? 8'hA5 : {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; add_valid = 1'b0; add_lines = 5'd0; apply_req = 1'b0; board_in = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic add(input logic [4:0] n);
        add_valid = 1'b1; add_lines = n;
        step();
        add_valid = 1'b0; add_lines = 5'd0;
    endtask

    function automatic logic [BW-1:0] exp_board(input logic [BW-1:0] b, input int n, input int hole);
        logic [BW-1:0] r;
        logic [11:0]   g;
        g = 12'hFFF;
        g[hole] = 1'b0;
        r = b;
        for (int i = 0; i < n; i++) r = {r[BW-13:0], g};
        return r;
    endfunction

    function automatic logic exp_top(input logic [BW-1:0] b, input int n);
        logic t;
        t = 1'b0;
        for (int i = 0; i < n; i++) t = t | (|b[(19-i)*12 +: 12]);
        return t;
    endfunction

    // Issues apply_req and waits (bounded) for done; lat = edges after the accepting edge
    task automatic do_apply(input logic [BW-1:0] b, output int lat, output int hole);
        hole = int'(lfsr_m % 8'd12);
        board_in = b; apply_req = 1'b1;
        step();
        apply_req = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (pending !== 5'd0) begin failures++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        checks++; if (board_out !== '0) begin failures++; $display("FAIL reset_board got=%h exp=0", board_out); end
        checks++; if (topout !== 1'b0) begin failures++; $display("FAIL reset_topout got=%0b exp=0", topout); end
        checks++; if (inserted !== 3'd0) begin failures++; $display("FAIL reset_inserted got=%0d exp=0", inserted); end
    endtask

    task automatic test_basic();
        int lat, hole;
        do_reset();
        add(5'd3);
        checks++; if (pending !== 5'd3) begin failures++; $display("FAIL basic_pending_add got=%0d exp=3", pending); end
        do_apply('0, lat, hole);
        checks++; if (lat !== 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        checks++; if (inserted !== 3'd3) begin failures++; $display("FAIL basic_inserted got=%0d exp=3", inserted); end
        checks++; if (board_out !== exp_board('0, 3, hole)) begin failures++; $display("FAIL basic_board got=%h exp=%h", board_out, exp_board('0, 3, hole)); end
        checks++; if (topout !== 1'b0) begin failures++; $display("FAIL basic_topout got=%0b exp=0", topout); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_done got=%0b exp=1", busy); end
        step();
        checks++; if (pending !== 5'd0) begin failures++; $display("FAIL basic_pending_after got=%0d exp=0", pending); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_saturate();
        int lat, hole;
        logic [BW-1:0] b;
        b = {48'h0, {16{12'h3C5}}};
        do_reset();
        add(5'd15);
        add(5'd15);
        checks++; if (pending !== 5'd20) begin failures++; $display("FAIL sat_pending got=%0d exp=20", pending); end
        do_apply(b, lat, hole);
        checks++; if (lat !== 4) begin failures++; $display("FAIL sat_latency got=%0d exp=4", lat); end
        checks++; if (inserted !== 3'd4) begin failures++; $display("FAIL sat_inserted got=%0d exp=4", inserted); end
        checks++; if (board_out !== exp_board(b, 4, hole)) begin failures++; $display("FAIL sat_board got=%h exp=%h", board_out, exp_board(b, 4, hole)); end
        checks++; if (board_out[59:48] !== 12'h3C5) begin failures++; $display("FAIL sat_row4 got=%h exp=3c5", board_out[59:48]); end
        step();
        checks++; if (pending !== 5'd16) begin failures++; $display("FAIL sat_pending_after got=%0d exp=16", pending); end
        // back-to-back apply drains another 4
        b = exp_board(b, 4, hole);
        do_apply(b, lat, hole);
        checks++; if (board_out !== exp_board(b, 4, hole)) begin failures++; $display("FAIL b2b_board got=%h exp=%h", board_out, exp_board(b, 4, hole)); end
        checks++; if (topout !== exp_top(b, 4)) begin failures++; $display("FAIL b2b_topout got=%0b exp=%0b", topout, exp_top(b, 4)); end
        step();
        checks++; if (pending !== 5'd12) begin failures++; $display("FAIL b2b_pending got=%0d exp=12", pending); end
        add(5'd20);
        checks++; if (pending !== 5'd20) begin failures++; $display("FAIL sat_clip got=%0d exp=20", pending); end
    endtask

    task automatic test_zero();
        int lat, hole;
        logic [BW-1:0] b;
        b = {20{12'h96A}};
        do_reset();
        do_apply(b, lat, hole);
        checks++; if (lat !== 0) begin failures++; $display("FAIL zero_latency got=%0d exp=0", lat); end
        checks++; if (board_out !== b) begin failures++; $display("FAIL zero_board got=%h exp=%h", board_out, b); end
        checks++; if (inserted !== 3'd0) begin failures++; $display("FAIL zero_inserted got=%0d exp=0", inserted); end
        checks++; if (topout !== 1'b0) begin failures++; $display("FAIL zero_topout got=%0b exp=0", topout); end
    endtask

    task automatic test_topout();
        int lat, hole;
        logic [BW-1:0] b;
        b = '0;
        b[239:228] = 12'h001;
        b[227:216] = 12'hABC;
        b[11:0]    = 12'h555;
        do_reset();
        add(5'd1);
        do_apply(b, lat, hole);
        checks++; if (topout !== 1'b1) begin failures++; $display("FAIL top_topout got=%0b exp=1", topout); end
        checks++; if (board_out[239:228] !== 12'hABC) begin failures++; $display("FAIL top_row19 got=%h exp=abc", board_out[239:228]); end
        checks++; if (board_out !== exp_board(b, 1, hole)) begin failures++; $display("FAIL top_board got=%h exp=%h", board_out, exp_board(b, 1, hole)); end
        checks++; if (inserted !== 3'd1) begin failures++; $display("FAIL top_inserted got=%0d exp=1", inserted); end
        step(); step(); step();
        checks++; if (board_out !== exp_board(b, 1, hole)) begin failures++; $display("FAIL hold_board got=%h exp=%h", board_out, exp_board(b, 1, hole)); end
        checks++; if (topout !== 1'b1) begin failures++; $display("FAIL hold_topout got=%0b exp=1", topout); end
        checks++; if (inserted !== 3'd1) begin failures++; $display("FAIL hold_inserted got=%0d exp=1", inserted); end
    endtask

    task automatic test_overlap();
        int lat, hole, extra;
        do_reset();
        add(5'd5);
        hole = int'(lfsr_m % 8'd12);
        board_in = '0; apply_req = 1'b1;
        step();
        apply_req = 1'b1;
        step();
        apply_req = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            step();
            lat++;
        end
        checks++; if (lat !== 4) begin failures++; $display("FAIL ovl_latency got=%0d exp=4", lat); end
        checks++; if (board_out !== exp_board('0, 4, hole)) begin failures++; $display("FAIL ovl_board got=%h exp=%h", board_out, exp_board('0, 4, hole)); end
        add(5'd2);
        checks++; if (pending !== 5'd3) begin failures++; $display("FAIL ovl_pending got=%0d exp=3", pending); end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) extra++;
            step();
        end
        checks++; if (extra !== 0) begin failures++; $display("FAIL ovl_extra_done got=%0d exp=0", extra); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ovl_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int seen;
        do_reset();
        add(5'd4);
        board_in = {20{12'hFFF}}; apply_req = 1'b1;
        step();
        apply_req = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy_shift got=%0b exp=1", busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b exp=0", busy); end
        checks++; if (pending !== 5'd0) begin failures++; $display("FAIL mid_pending got=%0d exp=0", pending); end
        checks++; if (board_out !== '0) begin failures++; $display("FAIL mid_board got=%h exp=0", board_out); end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) seen++;
            step();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_done got=%0d exp=0", seen); end
    endtask

    initial begin
        rst = 1'b1; add_valid = 1'b0; add_lines = 5'd0; apply_req = 1'b0; board_in = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturate();
        test_zero();
        test_topout();
        test_overlap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
